vga_line_fetch: RTL

Downstream consumer of the frame memory. It fetches one RAM word (one display row) during horizontal blanking and latches it into a line buffer. During active video it serializes the buffer into per-pixel colour codes. Sits between the frame memory and the VGA output/colour-mapping stage, and is driven by the timing generator's line_start and display-enable signals.

---
 rtl/vga_line_fetch_pkg.sv | 21 ++
 rtl/vga_line_fetch_if.sv | 24 ++
 rtl/vga_line_fetch_pixel_serializer.sv | 83 ++++++++
 rtl/vga_line_fetch.sv | 112 +++++++++++
 4 files changed

// File: rtl/vga_line_fetch_pkg.sv
// Shared types and default geometry for the VGA line fetch path.
// One RAM word holds one display row; each cell is one RGB code spanning CELL_PX pixels.
package vga_pkg;

  localparam int RAM_WIDTH     = 72;
  localparam int RAM_DEPTH     = 480;
  localparam int BITS_PER_CELL = 3;
  localparam int CELL_PX       = 26;
  localparam int H_ACTIVE      = 640;
  localparam int CELLS         = RAM_WIDTH / BITS_PER_CELL;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    READY  = 2'd2,
    ACTIVE = 2'd3
  } fetch_state_t;

  typedef logic [BITS_PER_CELL-1:0] colour_t;

endpackage

// File: rtl/vga_line_fetch_if.sv
// Frame-memory read port: registered address/enable out, combinational data back.
// The line fetcher is the master; the frame memory is the slave.
interface vga_mem_if import vga_pkg::*; #(
  parameter int AW = $clog2(vga_pkg::RAM_DEPTH),
  parameter int DW = vga_pkg::RAM_WIDTH
);

  logic [AW-1:0] mem_addr_out;
  logic          mem_re_out;
  logic [DW-1:0] mem_data_in;

  modport master (
    output mem_addr_out,
    output mem_re_out,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr_out,
    input  mem_re_out,
    output mem_data_in
  );

endinterface

// File: rtl/vga_line_fetch_pixel_serializer.sv
// Line buffer plus cell/sub-pixel counters; emits one colour code per pixel, 1-cycle latency.
// No backpressure: the pixel stream follows de_in unconditionally.
module vga_pixel_serializer import vga_pkg::*; #(
  parameter int RAM_WIDTH     = vga_pkg::RAM_WIDTH,
  parameter int BITS_PER_CELL = vga_pkg::BITS_PER_CELL,
  parameter int CELL_PX       = vga_pkg::CELL_PX
) (
  input  logic                     clk_in,
  input  logic                     rstn_in,
  input  logic                     load_en_in,
  input  logic [RAM_WIDTH-1:0]     load_data_in,
  input  logic                     cnt_clr_in,
  input  logic                     pix_en_in,
  input  logic                     de_in,
  output logic [BITS_PER_CELL-1:0] pixel_out,
  output logic                     pixel_valid_out
);

  localparam int CELL_CNT = RAM_WIDTH / BITS_PER_CELL;
  localparam int CW       = $clog2(CELL_CNT + 1);
  localparam int SW       = $clog2(CELL_PX);

  localparam logic [CW-1:0] CELL_LIM = CW'(CELL_CNT);
  localparam logic [SW-1:0] SUB_MAX  = SW'(CELL_PX - 1);

  logic [RAM_WIDTH-1:0]     buf_q;
  logic [SW-1:0]            sub_q, sub_d;
  logic [CW-1:0]            cell_q, cell_d;
  logic [BITS_PER_CELL-1:0] pix_q, pix_d;
  logic                     vld_q;
  logic [BITS_PER_CELL-1:0] cell_sel;

  always_comb begin
    sub_d  = sub_q;
    cell_d = cell_q;
    if (pix_en_in) begin
      if (sub_q == SUB_MAX) begin
        sub_d = '0;
        // Saturate one past the last cell so the right margin stays black.
        if (cell_q != CELL_LIM) begin
          cell_d = cell_q + CW'(1);
        end
      end else begin
        sub_d = sub_q + SW'(1);
      end
    end else if (cnt_clr_in) begin
      sub_d  = '0;
      cell_d = '0;
    end
  end

  always_comb begin
    cell_sel = '0;
    for (int k = 0; k < CELL_CNT; k++) begin
      if (cell_q == CW'(k)) begin
        cell_sel = buf_q[k*BITS_PER_CELL +: BITS_PER_CELL];
      end
    end
    pix_d = (pix_en_in && (cell_q < CELL_LIM)) ? cell_sel : '0;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      buf_q  <= '0;
      sub_q  <= '0;
      cell_q <= '0;
      pix_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (load_en_in) begin
        buf_q <= load_data_in;
      end
      sub_q  <= sub_d;
      cell_q <= cell_d;
      pix_q  <= pix_d;
      vld_q  <= de_in;
    end
  end

  assign pixel_out       = pix_q;
  assign pixel_valid_out = vld_q;

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches one row word during h-blank, then serializes it during active video (1-cycle latency).
// No backpressure: memory read is single-cycle and pixels track de_in directly.
module vga_line_fetch import vga_pkg::*; #(
  parameter int RAM_WIDTH     = vga_pkg::RAM_WIDTH,
  parameter int RAM_DEPTH     = vga_pkg::RAM_DEPTH,
  parameter int BITS_PER_CELL = vga_pkg::BITS_PER_CELL,
  parameter int CELL_PX       = vga_pkg::CELL_PX
) (
  input  logic                         clk_in,
  input  logic                         rstn_in,
  input  logic                         line_start_in,
  input  logic [$clog2(RAM_DEPTH)-1:0] row_in,
  input  logic                         de_in,
  vga_mem_if.master                    mem,
  output logic [BITS_PER_CELL-1:0]     pixel_out,
  output logic                         pixel_valid_out
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(RAM_DEPTH);

  fetch_state_t  state_q, state_d;
  logic          loaded_q, loaded_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          re_q, re_d;
  logic          row_ok;
  logic          pix_first;
  logic          pix_en;
  logic          load_en;
  logic          cnt_clr;
  logic [RAM_WIDTH-1:0] load_data;

  assign row_ok = ({1'b0, row_in} < DEPTH_C);

  // A line only starts on a rising de_in; a de period already running when
  // the fetch completes is left dark (pixel_valid_out is de_in one cycle late).
  assign pix_first = (state_q == READY) && de_in && !pixel_valid_out;

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    addr_d   = addr_q;
    re_d     = 1'b0;
    if (line_start_in) begin
      state_d  = FETCH;
      loaded_d = 1'b0;
      addr_d   = row_in;
      re_d     = row_ok;
    end else begin
      case (state_q)
        FETCH: begin
          state_d  = READY;
          loaded_d = 1'b1;
        end
        READY: begin
          if (pix_first) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (!de_in) begin
            state_d  = IDLE;
            loaded_d = 1'b0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      addr_q   <= '0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
    end
  end

  assign mem.mem_addr_out = addr_q;
  assign mem.mem_re_out   = re_q;

  // Out-of-range rows never assert re, so they load a blank line.
  assign load_en   = (state_q == FETCH);
  assign load_data = re_q ? mem.mem_data_in : '0;
  assign cnt_clr   = (state_q != ACTIVE);
  assign pix_en    = loaded_q && (((state_q == ACTIVE) && de_in) || pix_first);

  vga_pixel_serializer #(
    .RAM_WIDTH     (RAM_WIDTH),
    .BITS_PER_CELL (BITS_PER_CELL),
    .CELL_PX       (CELL_PX)
  ) u_ser (
    .clk_in          (clk_in),
    .rstn_in         (rstn_in),
    .load_en_in      (load_en),
    .load_data_in    (load_data),
    .cnt_clr_in      (cnt_clr),
    .pix_en_in       (pix_en),
    .de_in           (de_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out)
  );

endmodule
